// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART core.
// Both the transmit and receive engines use the same four-phase frame walk.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: two-flop synchronizer on rx, centre-sampling 8N1 frame decoder.
// Bytes with a bad stop bit are dropped without touching rx_data.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ready
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

    logic rx_meta;
    logic rx_sync;
    logic rx_prev;

    uart_state_e          state, state_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic [2:0]           bit_idx, bit_idx_nx;
    logic [DATA_BITS-1:0] shift, shift_nx;
    logic [7:0]           rx_data_nx;
    logic                 rx_ready_nx;
    logic                 armed, armed_nx;

    // Synchronizer resets to the idle level so reset never looks like a start edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_data  <= 8'h00;
            rx_ready <= 1'b0;
            armed    <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            bit_idx  <= bit_idx_nx;
            shift    <= shift_nx;
            rx_data  <= rx_data_nx;
            rx_ready <= rx_ready_nx;
            armed    <= armed_nx;
        end
    end

    // armed drops on a framing error so a line stuck low cannot retrigger a frame
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt + CW'(1);
        bit_idx_nx  = bit_idx;
        shift_nx    = shift;
        rx_data_nx  = rx_data;
        rx_ready_nx = 1'b0;
        armed_nx    = armed;

        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (rx_sync) begin
                    armed_nx = 1'b1;
                end
                if (armed && rx_prev && !rx_sync) begin
                    state_nx = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nx     = '0;
                    bit_idx_nx = '0;
                    state_nx   = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_nx   = '0;
                    shift_nx = {rx_sync, shift[DATA_BITS-1:1]};
                    if (bit_idx == BIT_LAST) begin
                        state_nx = STOP;
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                    if (rx_sync) begin
                        rx_data_nx  = shift;
                        rx_ready_nx = 1'b1;
                    end else begin
                        armed_nx = 1'b0;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: rtl/uart.sv
// Full-duplex 8N1 UART: transmitter here, receiver in uart_rx.
// The byte is captured at the end of the start bit because the feeding FIFO lags tx_req by a cycle.
module uart
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_req,
    input  logic [7:0] tx_data,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] rx_data,
    output logic       tx_ready,
    output logic       rx_ready
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

    uart_state_e          tx_state, tx_state_nx;
    logic [CW-1:0]        tx_cnt, tx_cnt_nx;
    logic [2:0]           tx_bit, tx_bit_nx;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_nx;
    logic                 tx_nx;
    logic                 tx_ready_nx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
            tx_ready <= 1'b0;
        end else begin
            tx_state <= tx_state_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_bit   <= tx_bit_nx;
            tx_shift <= tx_shift_nx;
            tx       <= tx_nx;
            tx_ready <= tx_ready_nx;
        end
    end

    // tx_ready is raised one clock early so the registered pulse covers the last stop clock,
    // which is also the only non-idle cycle where a new request is accepted
    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt + CW'(1);
        tx_bit_nx   = tx_bit;
        tx_shift_nx = tx_shift;
        tx_nx       = tx;
        tx_ready_nx = 1'b0;

        case (tx_state)
            IDLE: begin
                tx_nx     = 1'b1;
                tx_cnt_nx = '0;
                if (tx_req) begin
                    tx_state_nx = START;
                    tx_nx       = 1'b0;
                end
            end
            START: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_state_nx = DATA;
                    tx_cnt_nx   = '0;
                    tx_bit_nx   = '0;
                    tx_nx       = tx_data[0];
                    tx_shift_nx = {1'b0, tx_data[DATA_BITS-1:1]};
                end
            end
            DATA: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_nx = '0;
                    if (tx_bit == BIT_LAST) begin
                        tx_state_nx = STOP;
                        tx_nx       = 1'b1;
                    end else begin
                        tx_bit_nx   = tx_bit + 3'd1;
                        tx_nx       = tx_shift[0];
                        tx_shift_nx = {1'b0, tx_shift[DATA_BITS-1:1]};
                    end
                end
            end
            STOP: begin
                tx_ready_nx = (tx_cnt == CNT_PRE);
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_nx = '0;
                    if (tx_req) begin
                        tx_state_nx = START;
                        tx_nx       = 1'b0;
                    end else begin
                        tx_state_nx = IDLE;
                        tx_nx       = 1'b1;
                    end
                end
            end
            default: begin
                tx_state_nx = IDLE;
                tx_cnt_nx   = '0;
                tx_nx       = 1'b1;
            end
        endcase
    end

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .rx_data (rx_data),
        .rx_ready(rx_ready)
    );

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: frame-level reference model driven by directed and random bytes.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_uart;

    localparam int C     = 16;
    localparam int FRAME = 10 * C;
    localparam int LAST  = FRAME - 1;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       tx_req  = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       rx_drv  = 1'b1;
    logic       loop_en = 1'b0;
    logic       rx_line;
    logic       tx;
    logic       tx_ready;
    logic       rx_ready;
    logic [7:0] rx_data;

    int         tests_run = 0;
    int         failures  = 0;
    logic [7:0] exp_rx    = 8'h00;

    assign rx_line = loop_en ? tx : rx_drv;

    uart #(
        .CLKS_PER_BIT(C)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_req  (tx_req),
        .tx_data (tx_data),
        .rx      (rx_line),
        .tx      (tx),
        .rx_data (rx_data),
        .tx_ready(tx_ready),
        .rx_ready(rx_ready)
    );

    initial forever #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line must be quiet: tx high, no ready pulses
    task automatic idle_check(input string tag, input int cycles);
        int bad = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_ready !== 1'b0 || rx_ready !== 1'b0) bad++;
        end
        check_output(tag, bad, 0);
    endtask

    // Frame bit b of byte d: start, 8 data bits LSB first, stop
    function automatic logic frame_bit(input logic [7:0] d, input int b, input logic stop_bit);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9) return stop_bit;
        return 1'b1;
    endfunction

    // Entry with begin_req=0 assumes the previous frame already raised tx_req in its ready cycle
    task automatic tx_frame(input logic [7:0] d, input bit begin_req, input bit chain_next,
                            input int mid_at);
        int errs   = 0;
        int pulses = 0;
        int pos    = -1;
        if (begin_req) begin
            @(negedge clk);
            tx_req  = 1'b1;
            tx_data = ~d;
        end
        @(negedge clk);
        tx_req  = 1'b0;
        tx_data = d;
        for (int k = 0; k < FRAME; k++) begin
            if (tx !== frame_bit(d, k / C, 1'b1)) errs++;
            if (tx_ready === 1'b1) begin
                pulses++;
                pos = k;
            end
            if (k % C == C - 1) begin
                check_output($sformatf("tx_%02h_bit%0d_bad_cycles", d, k / C), errs, 0);
                errs = 0;
            end
            if (k == C) tx_data = 8'($urandom);
            tx_req = (k == mid_at) || (chain_next && k == LAST);
            if (k != LAST) @(negedge clk);
        end
        check_output($sformatf("tx_%02h_ready_pulses", d), pulses, 1);
        check_output($sformatf("tx_%02h_ready_cycle", d), pos, LAST);
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop_bit);
        int pulses = 0;
        int pos    = -1;
        for (int k = 0; k < FRAME + 2 * C; k++) begin
            @(negedge clk);
            if (rx_ready === 1'b1) begin
                pulses++;
                pos = k;
            end
            rx_drv = frame_bit(d, k / C, stop_bit);
        end
        if (stop_bit) exp_rx = d;
        check_output($sformatf("rx_%02h_stop%0d_pulses", d, stop_bit), pulses, 32'(stop_bit));
        if (stop_bit)
            check_output($sformatf("rx_%02h_pulse_in_stop_bit", d), 32'(pos >= 9 * C && pos < FRAME), 1);
        check_output($sformatf("rx_%02h_stop%0d_data", d, stop_bit), rx_data, exp_rx);
    endtask

    task automatic rx_glitch(input int low_cycles);
        int pulses = 0;
        for (int k = 0; k < 3 * C + low_cycles; k++) begin
            @(negedge clk);
            if (rx_ready === 1'b1) pulses++;
            rx_drv = (k < low_cycles) ? 1'b0 : 1'b1;
        end
        check_output("rx_glitch_pulses", pulses, 0);
        check_output("rx_glitch_data", rx_data, exp_rx);
    endtask

    task automatic loopback(input logic [7:0] d);
        int tx_pos = -1;
        int rx_pos = -1;
        int diff;
        loop_en = 1'b1;
        @(negedge clk);
        tx_req  = 1'b1;
        tx_data = ~d;
        @(negedge clk);
        tx_req  = 1'b0;
        tx_data = d;
        for (int k = 0; k < FRAME + 2 * C; k++) begin
            if (tx_ready === 1'b1) tx_pos = k;
            if (rx_ready === 1'b1) rx_pos = k;
            @(negedge clk);
        end
        loop_en = 1'b0;
        exp_rx  = d;
        diff    = (tx_pos > rx_pos) ? tx_pos - rx_pos : rx_pos - tx_pos;
        check_output($sformatf("loop_%02h_rx_data", d), rx_data, d);
        check_output($sformatf("loop_%02h_tx_ready_cycle", d), tx_pos, LAST);
        check_output($sformatf("loop_%02h_rx_seen", d), 32'(rx_pos >= 0), 1);
        check_output($sformatf("loop_%02h_ready_gap_le_bit", d), 32'(diff <= C), 1);
    endtask

    initial begin
        logic [7:0] r;

        repeat (3) @(negedge clk);
        check_output("reset_tx", tx, 1'b1);
        check_output("reset_tx_ready", tx_ready, 1'b0);
        check_output("reset_rx_ready", rx_ready, 1'b0);
        check_output("reset_rx_data", rx_data, 8'h00);
        reset = 1'b1;
        idle_check("post_reset_idle", 3 * C);

        tx_frame(8'hA5, 1'b1, 1'b1, -1);
        tx_frame(8'h3C, 1'b0, 1'b0, 5 * C + 3);
        idle_check("tx_idle_after_mid_req", 2 * C);
        for (int i = 0; i < 3; i++) begin
            r = 8'($urandom);
            tx_frame(r, 1'b1, 1'b0, C + int'($urandom_range(0, 8 * C)));
            idle_check("tx_idle_after_random", C);
        end

        rx_frame(8'h5A, 1'b1);
        rx_glitch(4);
        rx_frame(8'hFF, 1'b0);
        rx_frame(8'h00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            r = 8'($urandom);
            rx_frame(r, logic'($urandom_range(0, 3) != 0));
        end

        loopback(8'h81);
        for (int i = 0; i < 2; i++) begin
            r = 8'($urandom);
            loopback(r);
        end

        @(negedge clk);
        tx_req  = 1'b1;
        tx_data = 8'h77;
        rx_drv  = 1'b0;
        @(negedge clk);
        tx_req = 1'b0;
        repeat (40) @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("midframe_reset_tx", tx, 1'b1);
        check_output("midframe_reset_tx_ready", tx_ready, 1'b0);
        check_output("midframe_reset_rx_ready", rx_ready, 1'b0);
        check_output("midframe_reset_rx_data", rx_data, 8'h00);
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        exp_rx = 8'h00;
        idle_check("midframe_reset_release_idle", 3 * C);
        check_output("midframe_reset_rx_data_held", rx_data, exp_rx);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/uart.md
Name: uart

Overview:
- Full-duplex 8N1 UART core: one transmitter, one receiver, sharing a fixed baud divider derived from the system clock.
- Sits under the memory-mapped serial peripheral, which feeds it from a TX FIFO (tx_req/tx_data) and pushes received bytes into an RX FIFO (rx_ready/rx_data).
- No buffering inside; one byte in flight per direction.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200 baud, rounded); must be >= 4.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (low = reset).
- tx_req  input  1  single-cycle transmit request.
- tx_data  input  8  byte to send; must be stable from the cycle after tx_req through the end of the start bit.
- rx  input  1  serial input, asynchronous, idle high.
- tx  output  1  serial output, idle high.
- rx_data  output  8  last correctly framed received byte.
- tx_ready  output  1  one-cycle pulse: transmission finished.
- rx_ready  output  1  one-cycle pulse: new byte valid on rx_data.

Behaviour:
- Reset values: tx=1, tx_ready=0, rx_ready=0, rx_data=8'h00; both engines return to IDLE. Reset mid-frame aborts immediately and tx goes high.
- All outputs are registered.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity. Each bit lasts exactly CLKS_PER_BIT clocks.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If tx_req is sampled high, go to START; tx=0 from the next cycle.
  - tx_data is loaded into the shift register on the last clock of START (not at the tx_req edge), because the upstream FIFO presents the byte one cycle after tx_req.
  - DATA: shift out 8 bits LSB first.
  - STOP: tx=1 for CLKS_PER_BIT clocks. tx_ready is high during the final clock of STOP, i.e. exactly 10*CLKS_PER_BIT cycles after the tx_req sampling edge; then return to IDLE.
  - tx_req while not IDLE is ignored, except in the tx_ready cycle, where it starts the next frame back-to-back with no idle gap.
- RX path:
  - rx passes through a 2-flop synchronizer before use.
  - RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a synchronized falling edge (1 then 0) enters START.
  - START: at CLKS_PER_BIT/2 clocks, re-sample. If rx=1, treat it as a glitch and return to IDLE. Otherwise bit timing is centred there.
  - DATA: sample 8 bits at bit centres, each CLKS_PER_BIT apart, shifting in LSB first.
  - STOP: sample at the stop-bit centre. If 1, update rx_data and pulse rx_ready for one cycle in the same edge. If 0 (framing error), discard the byte: no rx_ready, rx_data unchanged. Then return to IDLE.
  - After a framing error, IDLE waits for rx=1 before re-arming edge detection.
  - rx_data holds its value until the next valid frame.
- TX and RX are fully independent; tx_ready and rx_ready may assert in the same cycle.
- Counters are sized clog2(CLKS_PER_BIT) bits plus a 3-bit bit index. Counters wrap cleanly with no overrun at 8 bits.

Decomposition:
- Package uart_pkg holds the state enum shared by both FSMs (IDLE, START, DATA, STOP) and the frame constants (DATA_BITS=8).
- CLKS_PER_BIT stays a module parameter.
- One sub-module, uart_rx (synchronizer + receive FSM). The transmitter lives in the top-level uart module.

Test Plan (CLKS_PER_BIT=16):
- Reset: hold reset low mid-frame -> tx=1, rx_ready=0, tx_ready=0, rx_data=00 immediately; after release, tx stays 1 with no tx_req.
- TX byte: tx_req pulse, tx_data=8'hA5 presented the next cycle -> tx low for 16 cycles, then bits 1,0,1,0,0,1,0,1 (16 cycles each), then high; tx_ready single pulse 160 cycles after the tx_req edge.
- Back-to-back TX: new tx_req in the tx_ready cycle with 8'h3C -> start bit begins the next cycle with no idle gap; a tx_req mid-frame is ignored (frame unchanged, a single tx_ready).
- RX byte: drive an 8'h5A frame at 16 clk/bit -> rx_ready one-cycle pulse within the stop bit, rx_data=5A held until the next frame.
- RX errors: 4-cycle low glitch -> no rx_ready. Frame 8'hFF with stop bit 0 -> no rx_ready, rx_data keeps 5A. A valid 8'h00 frame afterwards -> rx_ready, rx_data=00.
- Loopback tx->rx: send 8'h81 -> rx_data=81; rx_ready lands within 1 bit period of tx_ready, independent of each other.
